muller_c_hs_driver: RTL
=======================

// Module: muller_c_hs_driver
// PURPOSE
//  Clocked four-phase stimulus driver placed directly upstream of the Muller C-element.
//  It drives the element's two inputs through SET/HOLD/CLR/HOLD phases and samples its
//  output through a synchronizer. It checks both C-element laws: the output follows
//  agreeing inputs and holds its value on disagreeing inputs. Results are counted and
//  flagged on io pins.
// PARAMETERS
//  CNT_W       8   width of the round count request and the completed-round counter
//  TIMEOUT     15  max clocks to wait for the synchronized output to follow (>=SYNC_STAGES+1)
//  HOLD_CYC    4   clocks that disagreeing inputs are held while the output must stay stable
//  SYNC_STAGES 2   flops in the c_q_i synchronizer (>=2)
// PORTS
//  wb_clk_i   in   1      clock
//  wb_rst_i   in   1      reset, asynchronous, active-high
//  start_i    in   1      pulse or level; sampled in IDLE only
//  rounds_i   in   CNT_W  rounds to run; 0 = run until start_i is low at a round end
//  c_q_i      in   1      C-element output (asynchronous to wb_clk_i)
//  c_a_o      out  1      C-element input A (registered)
//  c_b_o      out  1      C-element input B (registered)
//  busy_o     out  1      high in any state other than IDLE/DONE/ERR
//  done_o     out  1      high in DONE
//  err_o      out  1      high in ERR (sticky until reset or next start)
//  err_code_o out  2      0 none, 1 rise timeout, 2 fall timeout, 3 hold violation
//  rounds_o   out  CNT_W  completed rounds; saturates at all-ones
// BEHAVIOUR
//  - Reset (async assert, sync deassert by design): all outputs 0, FSM=IDLE, sync chain=0.
//  - q_s = c_q_i after SYNC_STAGES flops. All checks use q_s only (latency SYNC_STAGES).
//  - FSM states; c_a_o/c_b_o are registered and change on state entry:
//    IDLE : a=0 b=0. start_i=1 -> SET; rounds_o cleared, err cleared, tmo=0.
//    SET  : a=1 b=1. Wait q_s==1 -> HOLD1 (tmo=0). tmo==TIMEOUT -> ERR code 1.
//    HOLD1: a=0 b=1 for HOLD_CYC clks. Any q_s==0 -> ERR code 3. Then -> CLR.
//    CLR  : a=0 b=0. Wait q_s==0 -> HOLD0. tmo==TIMEOUT -> ERR code 2.
//    HOLD0: a=1 b=0 for HOLD_CYC clks. Any q_s==1 -> ERR code 3.
//           At end: rounds_o+1 (saturating). Then:
//           if rounds_i!=0 and new count==rounds_i -> DONE;
//           else if rounds_i==0 and start_i==0 -> DONE; else -> SET.
//    DONE : a=0 b=0, done_o=1. start_i=1 -> SET with rounds_o cleared.
//    ERR  : a=0 b=0, err_o=1, code held, rounds_o frozen. start_i=1 -> SET, err cleared.
//  - The hold check skips the first SYNC_STAGES clks of HOLD1/HOLD0. The synchronizer
//    still carries pre-transition samples during that window, so only the later clks count.
//  - tmo is CNT width $clog2(TIMEOUT+1), cleared on every state entry, incremented each
//    clk while waiting. It never wraps: comparison to TIMEOUT precedes increment.
//  - A q_s match and a timeout in the same clk: the match wins (advance, no error).
//  - start_i is ignored while busy_o=1. rounds_i is sampled each HOLD0 end, not latched.
//  - A reset mid-round returns a/b to 0 immediately (async). No partial round is counted.
// STRUCTURE
//  - The shared package muller_c_pkg holds the state enum (IDLE,SET,HOLD1,CLR,HOLD0,DONE,ERR)
//    and the err_code constants ERR_NONE/ERR_RISE/ERR_FALL/ERR_HOLD.
//  - One sub-module: muller_c_sync (SYNC_STAGES-deep flop chain, async reset to 0).
//  - The FSM, tmo/hold counter and rounds counter live in this module.
// TESTING
//  1. Ideal C-element model (0-delay) with rounds_i=3 and a start pulse -> 3 rounds,
//     rounds_o=3, done_o=1, err_o=0, c_a_o/c_b_o=0 in DONE.
//  2. Model whose output is stuck at 0, start -> ERR after TIMEOUT+1 clks in SET,
//     err_code_o=1, rounds_o=0.
//  3. Model that acts as an AND gate instead of a C-element -> ERR in HOLD1,
//     err_code_o=3, rounds_o=0.
//  4. Model that acts as an OR gate -> ERR in HOLD0 of round 1 (q_s stays 1),
//     err_code_o=3.
//  5. rounds_i=0 with start held high for 5 rounds, then dropped mid-round ->
//     that round completes, rounds_o=6, done_o=1.
//  6. Assert wb_rst_i during HOLD1 of round 2 -> same clk: a=b=0, outputs 0, IDLE;
//     a new start restarts from rounds_o=0.

Source files
------------

// File: rtl/muller_c_pkg.sv
// rtl/muller_c_pkg.sv - shared state, error codes and output decode for the C-element driver
package muller_c_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET   = 3'd1,
        HOLD1 = 3'd2,
        CLR   = 3'd3,
        HOLD0 = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_RISE = 2'd1;
    localparam logic [1:0] ERR_FALL = 2'd2;
    localparam logic [1:0] ERR_HOLD = 2'd3;

    typedef struct packed {
        logic a;
        logic b;
        logic busy;
        logic done;
        logic err;
    } hs_outs_t;

    // Output pattern each state presents; loaded into the output register on state entry.
    function automatic hs_outs_t outs_of(input state_t s);
        hs_outs_t o;
        o = '0;
        case (s)
            SET:     begin o.a = 1'b1; o.b = 1'b1; o.busy = 1'b1; end
            HOLD1:   begin o.b = 1'b1; o.busy = 1'b1; end
            CLR:     o.busy = 1'b1;
            HOLD0:   begin o.a = 1'b1; o.busy = 1'b1; end
            DONE:    o.done = 1'b1;
            ERR:     o.err = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/muller_c_sync.sv
// rtl/muller_c_sync.sv - multi-flop synchronizer for the asynchronous C-element output
module muller_c_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/muller_c_hs_driver.sv
// rtl/muller_c_hs_driver.sv - four-phase stimulus driver and law checker for a Muller C-element
module muller_c_hs_driver
    import muller_c_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = 15,
    parameter int HOLD_CYC    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] rounds_i,
    input  logic             c_q_i,
    output logic             c_a_o,
    output logic             c_b_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [1:0]       err_code_o,
    output logic [CNT_W-1:0] rounds_o
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int HLD_W = $clog2(HOLD_CYC + 1);

    state_t           state;
    hs_outs_t         outs;
    logic [TMO_W-1:0] tmo;
    logic [HLD_W-1:0] hold_cnt;
    logic [CNT_W-1:0] rounds_inc;
    logic             q_s;
    logic             hold_armed;
    logic             hold_last;
    logic             tmo_hit;

    muller_c_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .d   (c_q_i),
        .q   (q_s)
    );

    // The first SYNC_STAGES clocks of a hold phase still see pre-transition samples.
    assign hold_armed = int'(hold_cnt) >= SYNC_STAGES;
    assign hold_last  = hold_cnt == HLD_W'(HOLD_CYC - 1);
    assign tmo_hit    = tmo == TMO_W'(TIMEOUT);
    assign rounds_inc = (rounds_o == '1) ? rounds_o : rounds_o + 1'b1;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            outs       <= '0;
            err_code_o <= ERR_NONE;
            rounds_o   <= '0;
            tmo        <= '0;
            hold_cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start_i) begin
                        state      <= SET;
                        outs       <= outs_of(SET);
                        rounds_o   <= '0;
                        err_code_o <= ERR_NONE;
                        tmo        <= '0;
                    end
                end
                SET: begin
                    if (q_s) begin
                        state    <= HOLD1;
                        outs     <= outs_of(HOLD1);
                        hold_cnt <= '0;
                    end else if (tmo_hit) begin
                        state      <= ERR;
                        outs       <= outs_of(ERR);
                        err_code_o <= ERR_RISE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                HOLD1: begin
                    if (hold_armed && !q_s) begin
                        state      <= ERR;
                        outs       <= outs_of(ERR);
                        err_code_o <= ERR_HOLD;
                    end else if (hold_last) begin
                        state <= CLR;
                        outs  <= outs_of(CLR);
                        tmo   <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                CLR: begin
                    if (!q_s) begin
                        state    <= HOLD0;
                        outs     <= outs_of(HOLD0);
                        hold_cnt <= '0;
                    end else if (tmo_hit) begin
                        state      <= ERR;
                        outs       <= outs_of(ERR);
                        err_code_o <= ERR_FALL;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                HOLD0: begin
                    if (hold_armed && q_s) begin
                        state      <= ERR;
                        outs       <= outs_of(ERR);
                        err_code_o <= ERR_HOLD;
                    end else if (hold_last) begin
                        rounds_o <= rounds_inc;
                        if ((rounds_i != '0 && rounds_inc == rounds_i) ||
                            (rounds_i == '0 && !start_i)) begin
                            state <= DONE;
                            outs  <= outs_of(DONE);
                        end else begin
                            state <= SET;
                            outs  <= outs_of(SET);
                            tmo   <= '0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    outs  <= '0;
                end
            endcase
        end
    end

    assign c_a_o  = outs.a;
    assign c_b_o  = outs.b;
    assign busy_o = outs.busy;
    assign done_o = outs.done;
    assign err_o  = outs.err;

endmodule
